sd_spi_card_model: RTL and testbench



---
 rtl/sd_spi_card_model.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sd_spi_card_model.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: decodes CMD17/CMD24 frames, serves single 64-bit
// blocks from an external synchronous memory and accepts 64-bit block writes.
`timescale 1ns/1ps
module sd_spi_card_model #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned NCR_CYC  = 8,
   parameter int unsigned NAC_CYC  = 16,
   parameter int unsigned NWR_CYC  = 2,
   parameter int unsigned BUSY_CYC = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   output logic              card_busy
);

   localparam int unsigned CMD_SH_W = 47;
   localparam int unsigned XFER_W   = 80;

   typedef enum logic [3:0] {
      IDLE, CMD_RX, NCR, R1_TX, W_HUNT, W_RX, NWR, DRESP_TX, BUSY, NAC, RD_TOKEN, RD_TX
   } state_e;

   function automatic logic [6:0] crc7_calc(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [15:0] crc16_calc(input logic [63:0] d);
      logic [15:0] c;
      logic        fb;
      c = '0;
      for (int i = 63; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   state_e                state_q, state_d;
   logic [6:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            gap_cnt_q, gap_cnt_d;
   logic [9:0]            busy_cnt_q, busy_cnt_d;
   logic [CMD_SH_W-1:0]   cmd_q, cmd_d;
   logic [XFER_W-1:0]     dat_q, dat_d;
   logic [7:0]            byte_q, byte_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  is_wr_q, is_wr_d;
   logic                  ok_q, ok_d;
   logic                  lat_q, lat_d;
   logic                  miso_q, miso_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [63:0]           mem_wdata_q, mem_wdata_d;
   logic                  card_busy_q, card_busy_d;

   // Command decode on the cycle the final frame bit arrives
   logic [47:0] frame_c;
   logic [5:0]  frame_idx;
   logic [31:0] frame_arg;
   logic [7:0]  r1_c;

   always_comb begin
      frame_c   = {cmd_q, MOSI};
      frame_idx = frame_c[45:40];
      frame_arg = frame_c[39:8];
      if (crc7_calc(frame_c[47:8]) != frame_c[7:1])          r1_c = 8'h08;
      else if (frame_idx != 6'd17 && frame_idx != 6'd24)      r1_c = 8'h04;
      else if ((frame_arg >> ADDR_W) != 32'd0)                r1_c = 8'h40;
      else                                                    r1_c = 8'h00;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      busy_cnt_d  = busy_cnt_q;
      cmd_d       = cmd_q;
      dat_d       = dat_q;
      byte_d      = byte_q;
      addr_d      = addr_q;
      is_wr_d     = is_wr_q;
      ok_d        = ok_q;
      lat_d       = mem_re_q;
      miso_d      = 1'b1;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      // Read data arrives the cycle after the strobe, independent of state
      if (lat_q) dat_d = {mem_rdata, crc16_calc(mem_rdata)};

      unique case (state_q)
         IDLE: begin
            if (!MOSI) begin
               state_d   = CMD_RX;
               cmd_d     = '0;
               bit_cnt_d = '0;
            end
         end
         CMD_RX: begin
            cmd_d     = {cmd_q[CMD_SH_W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'd46) begin
               if (frame_c[46] && frame_c[0]) begin
                  state_d   = NCR;
                  gap_cnt_d = '0;
                  byte_d    = r1_c;
                  ok_d      = (r1_c == 8'h00);
                  is_wr_d   = (frame_idx == 6'd24);
                  addr_d    = frame_arg[ADDR_W-1:0];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         NCR: begin
            if (gap_cnt_q == 8'(NCR_CYC - 1)) begin
               state_d   = R1_TX;
               miso_d    = byte_q[7];
               bit_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         R1_TX, DRESP_TX: begin
            if (bit_cnt_q != 7'd7) begin
               miso_d    = byte_q[6];
               byte_d    = {byte_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 7'd1;
            end else if (!ok_q) begin
               state_d = IDLE;
            end else if (state_q == DRESP_TX) begin
               state_d     = BUSY;
               miso_d      = 1'b0;
               busy_cnt_d  = '0;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = dat_q[XFER_W-1:16];
            end else if (is_wr_q) begin
               state_d = W_HUNT;
            end else begin
               state_d    = NAC;
               gap_cnt_d  = '0;
               mem_re_d   = 1'b1;
               mem_addr_d = addr_q;
            end
         end
         W_HUNT: begin
            if (!MOSI) begin
               state_d   = W_RX;
               bit_cnt_d = '0;
            end
         end
         W_RX: begin
            dat_d     = {dat_q[XFER_W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'(XFER_W - 1)) begin
               state_d   = NWR;
               gap_cnt_d = '0;
               ok_d      = (crc16_calc(dat_q[XFER_W-2:15]) == {dat_q[14:0], MOSI});
            end
         end
         NWR: begin
            if (gap_cnt_q == 8'(NWR_CYC - 1)) begin
               state_d   = DRESP_TX;
               byte_d    = ok_q ? 8'h05 : 8'h0B;
               miso_d    = 1'b0;
               bit_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         BUSY: begin
            if (busy_cnt_q == 10'(BUSY_CYC - 1)) begin
               state_d = IDLE;
            end else begin
               miso_d     = 1'b0;
               busy_cnt_d = busy_cnt_q + 10'd1;
            end
         end
         NAC: begin
            if (gap_cnt_q == 8'(NAC_CYC - 1)) begin
               state_d   = RD_TOKEN;
               bit_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         RD_TOKEN: begin
            // Token 0xFE: bit 7 is shown on entry, bit 0 is the only zero
            if (bit_cnt_q == 7'd7) begin
               state_d   = RD_TX;
               miso_d    = dat_q[XFER_W-1];
               dat_d     = {dat_q[XFER_W-2:0], 1'b1};
               bit_cnt_d = '0;
            end else begin
               miso_d    = (bit_cnt_q != 7'd6);
               bit_cnt_d = bit_cnt_q + 7'd1;
            end
         end
         RD_TX: begin
            if (bit_cnt_q == 7'(XFER_W - 1)) begin
               state_d = IDLE;
            end else begin
               miso_d    = dat_q[XFER_W-1];
               dat_d     = {dat_q[XFER_W-2:0], 1'b1};
               bit_cnt_d = bit_cnt_q + 7'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      card_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         busy_cnt_q  <= '0;
         cmd_q       <= '0;
         dat_q       <= '0;
         byte_q      <= '0;
         addr_q      <= '0;
         is_wr_q     <= 1'b0;
         ok_q        <= 1'b0;
         lat_q       <= 1'b0;
         miso_q      <= 1'b1;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         card_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         busy_cnt_q  <= busy_cnt_d;
         cmd_q       <= cmd_d;
         dat_q       <= dat_d;
         byte_q      <= byte_d;
         addr_q      <= addr_d;
         is_wr_q     <= is_wr_d;
         ok_q        <= ok_d;
         lat_q       <= lat_d;
         miso_q      <= miso_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         card_busy_q <= card_busy_d;
      end
   end

   assign MISO      = miso_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign card_busy = card_busy_q;

endmodule

// File: tb/tb_sd_spi_card_model.sv
// Directed bench for the SD SPI card model: reads, writes, command errors,
// data CRC error and reset in the middle of a read.
`timescale 1ns/1ps
module tb_sd_spi_card_model;

   localparam int unsigned ADDR_W = 16;
   localparam logic [63:0] RD_WORD = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] WR_WORD = 64'hDEAD_BEEF_0000_FFFF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              MOSI;
   logic              MISO;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;
   logic              card_busy;

   int checks = 0;
   int errors = 0;
   int re_cnt = 0;
   int we_cnt = 0;
   logic [15:0] re_addr = '0;
   logic [15:0] we_addr = '0;
   logic [63:0] we_data = '0;

   always #5 clk = ~clk;

   sd_spi_card_model #(
      .ADDR_W(ADDR_W), .NCR_CYC(8), .NAC_CYC(16), .NWR_CYC(2), .BUSY_CYC(32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .card_busy (card_busy)
   );

   // Memory: data only valid the cycle after a strobe, junk otherwise
   always @(posedge clk)
      mem_rdata <= mem_re ? ((mem_addr == 16'h1234) ? RD_WORD : 64'h0) : 64'hA5A5_5A5A_C3C3_3C3C;

   always @(negedge clk) begin
      if (mem_re === 1'b1) begin re_cnt++; re_addr = mem_addr; end
      if (mem_we === 1'b1) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] tb_crc7(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--)
         c = (c[6] ^ d[i]) ? ({c[5:0], 1'b0} ^ 7'h09) : {c[5:0], 1'b0};
      return c;
   endfunction

   function automatic logic [15:0] tb_crc16(input logic [63:0] d);
      logic [15:0] c;
      c = '0;
      for (int i = 63; i >= 0; i--)
         c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   function automatic logic [47:0] build_cmd(input logic [5:0] idx, input logic [31:0] arg,
                                             input logic flip);
      logic [39:0] h;
      logic [6:0]  c;
      h = {2'b01, idx, arg};
      c = tb_crc7(h);
      if (flip) c[0] = ~c[0];
      return {h, c, 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic din, output logic dout);
      @(negedge clk);
      dout = MISO;
      MOSI = din;
   endtask

   task automatic send(input logic [63:0] v, input int n);
      logic dummy;
      for (int i = n - 1; i >= 0; i--) cyc(v[i], dummy);
   endtask

   task automatic rx(input int n, output logic [63:0] v);
      logic b;
      v = '0;
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, b);
         v = {v[62:0], b};
      end
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [63:0] word);
      logic [63:0] v;
      int re0;
      re0 = re_cnt;
      send(64'(build_cmd(6'd17, {16'h0, addr}, 1'b0)), 48);
      rx(8, v);  chk("rd_ncr", v, 64'hFF);
      rx(8, v);  chk("rd_r1", v, 64'h00);
      chk("rd_busy", 64'(card_busy), 64'd1);
      rx(16, v); chk("rd_nac", v, 64'hFFFF);
      rx(8, v);  chk("rd_token", v, 64'hFE);
      rx(64, v); chk("rd_data", v, word);
      rx(16, v); chk("rd_crc", v, 64'(tb_crc16(word)));
      rx(8, v);  chk("rd_tail", v, 64'hFF);
      chk("rd_re_cnt", 64'(re_cnt - re0), 64'd1);
      chk("rd_re_addr", 64'(re_addr), 64'(addr));
      chk("rd_idle", 64'(card_busy), 64'd0);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [63:0] word, input logic bad);
      logic [63:0] v;
      logic [15:0] c;
      int we0;
      we0 = we_cnt;
      send(64'(build_cmd(6'd24, {16'h0, addr}, 1'b0)), 48);
      rx(8, v); chk("wr_ncr", v, 64'hFF);
      rx(8, v); chk("wr_r1", v, 64'h00);
      send(64'hFF, 8);
      send(64'hFE, 8);
      send(word, 64);
      c = tb_crc16(word);
      if (bad) c[0] = ~c[0];
      send(64'(c), 16);
      rx(2, v); chk("wr_nwr", v, 64'h3);
      if (!bad) begin
         rx(8, v);  chk("wr_dresp", v, 64'h05);
         rx(32, v); chk("wr_busy_low", v, 64'h0);
         rx(8, v);  chk("wr_tail", v, 64'hFF);
         chk("wr_we_cnt", 64'(we_cnt - we0), 64'd1);
         chk("wr_we_addr", 64'(we_addr), 64'(addr));
         chk("wr_we_data", we_data, word);
      end else begin
         rx(8, v);  chk("wr_dresp_bad", v, 64'h0B);
         rx(32, v); chk("wr_no_busy", v, 64'hFFFF_FFFF);
         chk("wr_no_we", 64'(we_cnt - we0), 64'd0);
      end
      chk("wr_idle", 64'(card_busy), 64'd0);
   endtask

   task automatic do_err_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic flip,
                             input logic [7:0] exp_r1);
      logic [63:0] v;
      int re0;
      re0 = re_cnt;
      send(64'(build_cmd(idx, arg, flip)), 48);
      rx(8, v);  chk("err_ncr", v, 64'hFF);
      rx(8, v);  chk("err_r1", v, 64'(exp_r1));
      rx(40, v); chk("err_no_data", v, 64'hFF_FFFF_FFFF);
      chk("err_no_re", 64'(re_cnt - re0), 64'd0);
      chk("err_idle", 64'(card_busy), 64'd0);
   endtask

   initial begin
      logic [63:0] v;
      MOSI  = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_miso", 64'(MISO), 64'd1);
      chk("rst_busy", 64'(card_busy), 64'd0);
      chk("rst_re", 64'(mem_re), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      do_read(16'h1234, RD_WORD);
      do_write(16'h0042, WR_WORD, 1'b0);

      do_err_cmd(6'd17, 32'h0000_1234, 1'b1, 8'h08);
      do_read(16'h1234, RD_WORD);
      do_err_cmd(6'd13, 32'h0000_0000, 1'b0, 8'h04);
      do_err_cmd(6'd17, 32'h0001_0000, 1'b0, 8'h40);

      do_write(16'h0042, WR_WORD, 1'b1);

      // Reset while data bit 20 of a read is on MISO
      send(64'(build_cmd(6'd17, 32'h0000_1234, 1'b0)), 48);
      rx(8, v);  chk("mid_ncr", v, 64'hFF);
      rx(8, v);  chk("mid_r1", v, 64'h00);
      rx(16, v); chk("mid_nac", v, 64'hFFFF);
      rx(8, v);  chk("mid_token", v, 64'hFE);
      rx(20, v); chk("mid_data20", v, 64'(RD_WORD[63:44]));
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_miso", 64'(MISO), 64'd1);
      chk("mid_rst_busy", 64'(card_busy), 64'd0);
      rx(16, v); chk("mid_quiet", v, 64'hFFFF);
      do_read(16'h1234, RD_WORD);
      chk("mid_no_we", 64'(we_cnt), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
